// File: rtl/mcp4921_dac_spi_axis.sv
// rtl/mcp4921_dac_spi_axis.sv - AXI-Stream fed SPI master for the MCP4921 12-bit DAC
//
// Purpose: takes one sample per stream handshake, converts it to a 12-bit DAC
// code (optionally from signed with saturation), frames it as the DAC write
// command, shifts it out in SPI mode 0,0 and then pulses LDAC to update the
// analog output.
//
// Ports:
//   clk                in   system clock, rising edge
//   rst                in   synchronous active-high reset
//   s_axis_dac_tdata   in   16-bit sample word
//   s_axis_dac_tvalid  in   sample valid
//   s_axis_dac_tready  out  high only while idle and ready for a sample
//   sck                out  SPI clock, idles low
//   mosi               out  SPI data, MSB first
//   cs                 out  DAC chip select, active low
//   ldac               out  DAC latch strobe, active low
module mcp4921_dac_spi_axis #(
  parameter int unsigned FCLK      = 125_000_000,
  parameter int unsigned SCK_DIV   = 10,
  parameter int unsigned CSH_CLKS  = 8,
  parameter int unsigned LDAC_CLKS = 8,
  parameter bit          DATA_FMT  = 1'b1,
  parameter bit          BUF       = 1'b0,
  parameter bit          GA_N      = 1'b1,
  parameter bit          SHDN_N    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_axis_dac_tdata,
  input  logic        s_axis_dac_tvalid,
  output logic        s_axis_dac_tready,
  output logic        sck,
  output logic        mosi,
  output logic        cs,
  output logic        ldac
);

  localparam int unsigned DIV_W    = $clog2(SCK_DIV);
  localparam int unsigned HOLD_MAX = (CSH_CLKS > LDAC_CLKS) ? CSH_CLKS : LDAC_CLKS;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(SCK_DIV / 2);
  localparam logic [HOLD_W-1:0] CSH_LAST  = HOLD_W'(CSH_CLKS - 1);
  localparam logic [HOLD_W-1:0] LDAC_LAST = HOLD_W'(LDAC_CLKS - 1);

  // Reject parameter sets the timing below cannot honour.
  if (FCLK == 0 || SCK_DIV < 10 || (SCK_DIV % 2) != 0 ||
      CSH_CLKS < 1 || LDAC_CLKS < 1) begin : g_param_check
    $error("mcp4921_dac_spi_axis: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CSH,
    S_LDAC
  } state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_cnt, div_d;
  logic [3:0]        bit_cnt, bit_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [15:0]       shreg, shreg_d;
  logic              sck_d, mosi_d, cs_d, ldac_d, tready_d;

  // Sample conversion. 17-bit signed keeps the clamp free of overflow for
  // every 16-bit input.
  logic signed [16:0] samp_s;
  logic signed [16:0] sat_s;
  logic [11:0]        code;
  logic [15:0]        frame;

  always_comb begin
    samp_s = {s_axis_dac_tdata[15], s_axis_dac_tdata};
    if (samp_s > 17'sd2047) begin
      sat_s = 17'sd2047;
    end else if (samp_s < -17'sd2048) begin
      sat_s = -17'sd2048;
    end else begin
      sat_s = samp_s;
    end
    code  = DATA_FMT ? 12'(sat_s + 17'sd2048) : s_axis_dac_tdata[11:0];
    frame = {1'b0, BUF, GA_N, SHDN_N, code};
  end

  // Next-state and next-output logic. Every pin is registered from these
  // values so the SPI and LDAC lines never glitch.
  always_comb begin
    state_d  = state;
    div_d    = div_cnt;
    bit_d    = bit_cnt;
    hold_d   = hold_cnt;
    shreg_d  = shreg;
    sck_d    = sck;
    mosi_d   = mosi;
    cs_d     = cs;
    ldac_d   = ldac;
    tready_d = s_axis_dac_tready;

    case (state)
      S_IDLE: begin
        cs_d     = 1'b1;
        ldac_d   = 1'b1;
        sck_d    = 1'b0;
        tready_d = 1'b1;
        if (s_axis_dac_tvalid && s_axis_dac_tready) begin
          state_d  = S_SHIFT;
          tready_d = 1'b0;
          cs_d     = 1'b0;
          // Bit 15 goes on the wire right away; the rest waits in the shifter.
          mosi_d   = frame[15];
          shreg_d  = {frame[14:0], 1'b0};
          div_d    = '0;
          bit_d    = '0;
        end
      end

      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_d = '0;
          sck_d = 1'b0;
          if (bit_cnt == 4'd15) begin
            state_d = S_CSH;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            hold_d  = '0;
          end else begin
            // Falling sck edge: present the next bit for the DAC's rising-edge sample.
            bit_d   = bit_cnt + 4'd1;
            mosi_d  = shreg[15];
            shreg_d = {shreg[14:0], 1'b0};
          end
        end else begin
          div_d = div_cnt + 1'b1;
          sck_d = (div_d >= DIV_HALF);
        end
      end

      S_CSH: begin
        if (hold_cnt == CSH_LAST) begin
          state_d = S_LDAC;
          ldac_d  = 1'b0;
          hold_d  = '0;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end

      S_LDAC: begin
        if (hold_cnt == LDAC_LAST) begin
          state_d  = S_IDLE;
          ldac_d   = 1'b1;
          tready_d = 1'b1;
          hold_d   = '0;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      div_cnt           <= '0;
      bit_cnt           <= '0;
      hold_cnt          <= '0;
      shreg             <= '0;
      sck               <= 1'b0;
      mosi              <= 1'b0;
      cs                <= 1'b1;
      ldac              <= 1'b1;
      s_axis_dac_tready <= 1'b0;
    end else begin
      state             <= state_d;
      div_cnt           <= div_d;
      bit_cnt           <= bit_d;
      hold_cnt          <= hold_d;
      shreg             <= shreg_d;
      sck               <= sck_d;
      mosi              <= mosi_d;
      cs                <= cs_d;
      ldac              <= ldac_d;
      s_axis_dac_tready <= tready_d;
    end
  end

endmodule

// File: tb/tb_mcp4921_dac_spi_axis.sv
// tb/tb_mcp4921_dac_spi_axis.sv - self-checking bench for mcp4921_dac_spi_axis
//
// Instance 0 runs with DATA_FMT = 0 (raw 12-bit), instance 1 with DATA_FMT = 1
// (signed, saturated, offset). Both share clk and rst.
module tb_mcp4921_dac_spi_axis;

  localparam int SCK_DIV   = 10;
  localparam int CSH_CLKS  = 8;
  localparam int LDAC_CLKS = 8;
  localparam int PERIOD    = 1 + 16 * SCK_DIV + CSH_CLKS + LDAC_CLKS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0][15:0] tdata;
  logic [1:0]       tvalid;
  logic [1:0]       tready, sck, mosi, cs, ldac;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp_q [2][$];
  int          acc_q [2][$];
  int          n_done [2];

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcp4921_dac_spi_axis #(
    .SCK_DIV(SCK_DIV), .CSH_CLKS(CSH_CLKS), .LDAC_CLKS(LDAC_CLKS), .DATA_FMT(1'b0)
  ) u_dut_raw (
    .clk(clk), .rst(rst),
    .s_axis_dac_tdata(tdata[0]), .s_axis_dac_tvalid(tvalid[0]), .s_axis_dac_tready(tready[0]),
    .sck(sck[0]), .mosi(mosi[0]), .cs(cs[0]), .ldac(ldac[0])
  );

  mcp4921_dac_spi_axis #(
    .SCK_DIV(SCK_DIV), .CSH_CLKS(CSH_CLKS), .LDAC_CLKS(LDAC_CLKS), .DATA_FMT(1'b1)
  ) u_dut_sgn (
    .clk(clk), .rst(rst),
    .s_axis_dac_tdata(tdata[1]), .s_axis_dac_tvalid(tvalid[1]), .s_axis_dac_tready(tready[1]),
    .sck(sck[1]), .mosi(mosi[1]), .cs(cs[1]), .ldac(ldac[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Reference: the DAC command word expected on the wire for a stream word.
  function automatic logic [15:0] model_frame(input int fmt, input logic [15:0] d);
    int v;
    if (fmt == 0) begin
      v = int'(d[11:0]);
    end else begin
      v = int'($signed(d));
      if (v > 2047)  v = 2047;
      if (v < -2048) v = -2048;
      v = v + 2048;
    end
    return 16'h3000 | 16'(v);
  endfunction

  // Per-instance wire monitor: captures mosi on sck rises inside cs low and
  // checks frame content and timing relative to the accepting cycle.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    int          acc_cyc   = 0;
    int          nrise     = 0;
    int          ldac_fall = 0;
    logic [15:0] cap       = '0;
    bit          in_frame  = 1'b0;
    bit          aborted   = 1'b0;
    bit          pend_ldac = 1'b0;
    logic        sck_p = 1'b0, cs_p = 1'b1, ldac_p = 1'b1;

    always @(negedge clk) begin
      logic [15:0] want;
      if (rst && in_frame) aborted = 1'b1;
      if (!rst && tvalid[g] && tready[g]) begin
        acc_cyc = cyc;
        acc_q[g].push_back(cyc);
        in_frame = 1'b1;
        nrise = 0;
        cap = '0;
      end
      if (!cs[g] && cs_p) check("cs_fall_t", cyc - acc_cyc, 1);
      if (!cs[g] && sck[g] && !sck_p) begin
        cap = {cap[14:0], mosi[g]};
        nrise++;
        if (nrise == 1) check("first_sck_t", cyc - acc_cyc, 1 + SCK_DIV / 2);
      end
      if (cs[g] && !cs_p) begin
        in_frame = 1'b0;
        if (aborted) begin
          check("abort_short", (nrise < 16), 1);
          if (exp_q[g].size() > 0) want = exp_q[g].pop_front();
          aborted = 1'b0;
        end else if (exp_q[g].size() == 0) begin
          check("unexpected_frame", cap, 0);
        end else begin
          want = exp_q[g].pop_front();
          check("frame", cap, want);
          check("sck_rises", nrise, 16);
          check("cs_rise_t", cyc - acc_cyc, 1 + 16 * SCK_DIV);
          pend_ldac = 1'b1;
        end
      end
      if (!ldac[g] && ldac_p) begin
        ldac_fall = cyc;
        if (!pend_ldac) check("spurious_ldac", 1, 0);
        else check("ldac_fall_t", cyc - acc_cyc, 1 + 16 * SCK_DIV + CSH_CLKS);
      end
      if (ldac[g] && !ldac_p) begin
        check("ldac_width", cyc - ldac_fall, LDAC_CLKS);
        check("tready_at_ldac_rise", tready[g], 1);
        pend_ldac = 1'b0;
        n_done[g]++;
      end
      sck_p  = sck[g];
      cs_p   = cs[g];
      ldac_p = ldac[g];
    end
  end

  // Offers one word, waits for the handshake and the end of its LDAC pulse.
  task automatic send(input int idx, input logic [15:0] d);
    int done0;
    int budget;
    done0 = n_done[idx];
    tdata[idx]  = d;
    tvalid[idx] = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!tready[idx] && budget < 400);
    if (!tready[idx]) check("accept_timeout", 0, 1);
    else exp_q[idx].push_back(model_frame(idx, d));
    @(posedge clk); #1;
    tvalid[idx] = 1'b0;
    tdata[idx]  = 16'($urandom);
    budget = 0;
    while (n_done[idx] == done0 && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    if (n_done[idx] == done0) check("frame_timeout", 0, 1);
    #1;
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dir_vec [7];
    logic [15:0] d;
    int budget, base, start, viol, done0;

    n_done[0] = 0;
    n_done[1] = 0;
    tdata  = '0;
    tvalid = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs, 2'b11);
    check("rst_sck", sck, 2'b00);
    check("rst_mosi", mosi, 2'b00);
    check("rst_ldac", ldac, 2'b11);
    check("rst_tready", tready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("tready_after_rst", tready, 2'b11);
    @(posedge clk); #1;

    // Raw format
    send(0, 16'h0ABC);
    for (int i = 0; i < 6; i++) send(0, 16'($urandom));

    // Signed format: directed saturation edges, then random
    dir_vec = '{16'hFF9C, 16'h7FFF, 16'h8000, 16'h07FF, 16'hF800, 16'h0800, 16'hF7FF};
    for (int i = 0; i < 7; i++) send(1, dir_vec[i]);
    for (int i = 0; i < 10; i++) send(1, 16'($urandom));

    // Back-to-back stream with tvalid held high
    base  = acc_q[1].size();
    done0 = n_done[1];
    d = 16'h0100;
    tdata[1]  = d;
    tvalid[1] = 1'b1;
    for (int n = 0; n < 6; n++) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!tready[1] && budget < 400);
      if (!tready[1]) check("stream_accept_timeout", 0, 1);
      else exp_q[1].push_back(model_frame(1, d));
      @(posedge clk); #1;
      d = d + 16'd1;
      tdata[1] = d;
    end
    tvalid[1] = 1'b0;
    budget = 0;
    while (n_done[1] < done0 + 6 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("stream_frames", n_done[1] - done0, 6);
    check("stream_accepts", acc_q[1].size() - base, 6);
    for (int i = base + 1; i < acc_q[1].size(); i++)
      check("stream_period", acc_q[1][i] - acc_q[1][i-1], PERIOD);

    // Idle for 1000 cycles: lines static, ready held
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cs[1] !== 1'b1 || ldac[1] !== 1'b1 || sck[1] !== 1'b0 || tready[1] !== 1'b1) viol++;
    end
    check("idle_static", viol, 0);
    @(posedge clk); #1;
    start = cyc;
    send(1, 16'h0123);
    check("accept_first_cycle", acc_q[1][acc_q[1].size()-1], start);

    // Reset during the 7th bit of a frame
    tdata[1]  = 16'h0555;
    tvalid[1] = 1'b1;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!tready[1] && budget < 400);
    if (!tready[1]) check("abort_accept_timeout", 0, 1);
    else exp_q[1].push_back(model_frame(1, 16'h0555));
    @(posedge clk); #1;
    tvalid[1] = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs", cs[1], 1);
    check("abort_sck", sck[1], 0);
    check("abort_mosi", mosi[1], 0);
    check("abort_ldac", ldac[1], 1);
    check("abort_tready", tready[1], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_tready_after", tready[1], 1);
    repeat (250) @(posedge clk);
    #1;
    send(1, 16'hFFFF);

    check("raw_queue_empty", exp_q[0].size(), 0);
    check("sgn_queue_empty", exp_q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
